// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline inter-stage registers.
package pipe_pkg;

    localparam int unsigned PIPE_INSTR_W = 32;
    localparam int unsigned PIPE_ADDR_W  = 32;
    localparam int unsigned PIPE_EXC_W   = 5;

    localparam logic [PIPE_EXC_W-1:0]   EXC_NONE         = 5'd0;
    localparam logic [PIPE_EXC_W-1:0]   EXC_ADEL         = 5'd4;
    localparam logic [PIPE_INSTR_W-1:0] NOP              = 32'h0000_0000;
    localparam logic [PIPE_ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;

    // Payload carried between stages at the default pipeline widths
    typedef struct packed {
        logic [PIPE_INSTR_W-1:0] instr;
        logic [PIPE_ADDR_W-1:0]  pc;
        logic [PIPE_ADDR_W-1:0]  pc4;
        logic                    valid;
        logic                    bd;
        logic [PIPE_EXC_W-1:0]   exc;
    } stage_payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear for performance monitoring.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise increment until all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register for the 5-stage MIPS pipeline with stall,
// flush (bubble), optional fetch-alignment check and perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       INSTR_W     = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       EXC_W       = 5,
    parameter int unsigned       CNT_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       KEEP_PC     = 1,
    parameter int unsigned       CHECK_ALIGN = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               En,
    input  logic               Flush,
    input  logic               CntClr,
    input  logic [INSTR_W-1:0] Instr_I,
    input  logic [ADDR_W-1:0]  PC_I,
    input  logic               Valid_I,
    input  logic               BD_I,
    input  logic [EXC_W-1:0]   ExcCode_I,
    output logic [INSTR_W-1:0] Instr_O,
    output logic [ADDR_W-1:0]  PC_O,
    output logic [ADDR_W-1:0]  PC4_O,
    output logic               Valid_O,
    output logic               BD_O,
    output logic [EXC_W-1:0]   ExcCode_O,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   FlushCnt
);

    localparam bit KEEP_ON  = (KEEP_PC != 0);
    localparam bit ALIGN_ON = (CHECK_ALIGN != 0);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [ADDR_W-1:0]  pc4_q,   pc4_d;
    logic               valid_q, valid_d;
    logic               bd_q,    bd_d;
    logic [EXC_W-1:0]   exc_q,   exc_d;
    logic               adel;
    logic               stall_inc;

    // Misaligned fetch of a real instruction with no earlier exception
    always_comb begin
        adel = ALIGN_ON && Valid_I && (PC_I[1:0] != 2'b00)
               && (ExcCode_I == EXC_W'(EXC_NONE));
    end

    // Next payload: flush > stall (hold) > load; PC+4 follows the new PC
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        if (Flush) begin
            instr_d = INSTR_W'(NOP);
            valid_d = 1'b0;
            exc_d   = EXC_W'(EXC_NONE);
            pc_d    = KEEP_ON ? PC_I : '0;
            bd_d    = KEEP_ON ? BD_I : 1'b0;
        end else if (En) begin
            instr_d = Instr_I;
            pc_d    = PC_I;
            valid_d = Valid_I;
            bd_d    = BD_I;
            exc_d   = ExcCode_I;
            if (adel) begin
                instr_d = INSTR_W'(NOP);
                valid_d = 1'b1;
                exc_d   = EXC_W'(EXC_ADEL);
            end
        end
        pc4_d = pc_d + ADDR_W'(4);
    end

    // Payload register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_q <= INSTR_W'(NOP);
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + ADDR_W'(4);
            valid_q <= 1'b0;
            bd_q    <= 1'b0;
            exc_q   <= EXC_W'(EXC_NONE);
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
        end
    end

    // A stall only counts while a real instruction is being held
    always_comb begin
        stall_inc = !Flush && !En && valid_q;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (stall_inc),
        .clr   (CntClr),
        .count (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .inc   (Flush),
        .clr   (CntClr),
        .count (FlushCnt)
    );

    assign Instr_O   = instr_q;
    assign PC_O      = pc_q;
    assign PC4_O     = pc4_q;
    assign Valid_O   = valid_q;
    assign BD_O      = bd_q;
    assign ExcCode_O = exc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one F/D-style instance (alignment check,
// 4-bit counters, bubbles keep PC) and one with bubbles zeroing PC/BD.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        en, fl, clr, valid_i, bd_i;
    logic [31:0] instr_i, pc_i;
    logic [4:0]  exc_i;

    logic [31:0] a_instr, a_pc, a_pc4;
    logic        a_valid, a_bd;
    logic [4:0]  a_exc;
    logic [3:0]  a_sc, a_fc;

    logic [31:0] b_instr, b_pc, b_pc4;
    logic        b_valid, b_bd;
    logic [4:0]  b_exc;
    logic [15:0] b_sc, b_fc;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_reg #(.CNT_W(4), .KEEP_PC(1), .CHECK_ALIGN(1)) dut_a (
        .Clk(clk), .Reset(rst), .En(en), .Flush(fl), .CntClr(clr),
        .Instr_I(instr_i), .PC_I(pc_i), .Valid_I(valid_i), .BD_I(bd_i), .ExcCode_I(exc_i),
        .Instr_O(a_instr), .PC_O(a_pc), .PC4_O(a_pc4), .Valid_O(a_valid), .BD_O(a_bd),
        .ExcCode_O(a_exc), .StallCnt(a_sc), .FlushCnt(a_fc)
    );

    pipe_stage_reg #(.CNT_W(16), .KEEP_PC(0), .CHECK_ALIGN(0)) dut_b (
        .Clk(clk), .Reset(rst), .En(en), .Flush(fl), .CntClr(clr),
        .Instr_I(instr_i), .PC_I(pc_i), .Valid_I(valid_i), .BD_I(bd_i), .ExcCode_I(exc_i),
        .Instr_O(b_instr), .PC_O(b_pc), .PC4_O(b_pc4), .Valid_O(b_valid), .BD_O(b_bd),
        .ExcCode_O(b_exc), .StallCnt(b_sc), .FlushCnt(b_fc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en, fl, clr, valid, bd;
        logic [31:0] instr, pc;
        logic [4:0]  exc;
        logic [31:0] e_instr, e_pc, e_pc4;
        logic        e_valid, e_bd;
        logic [4:0]  e_exc;
        logic [3:0]  e_sc, e_fc;
        logic [31:0] b_pc, b_pc4;
        logic        b_bd;
        logic [4:0]  b_exc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic c, input logic v,
                         input logic b, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [4:0] ex);
        en = e; fl = f; clr = c; valid_i = v; bd_i = b; instr_i = ins; pc_i = pc; exc_i = ex;
    endtask

    vec_t vecs[13];

    initial begin
        //         en fl clr v  bd instr         pc            exc    e_instr       e_pc          e_pc4         ev eb eexc   sc    fc    b_pc          b_pc4         bb bexc
        vecs[0]  = '{1,0,0,1,0, 32'h24010005, 32'h00003010, 5'd0, 32'h24010005, 32'h00003010, 32'h00003014, 1,0, 5'd0, 4'd0, 4'd0, 32'h00003010, 32'h00003014, 0, 5'd0};
        vecs[1]  = '{0,0,0,1,1, 32'hDEADBEEF, 32'h00003050, 5'd3, 32'h24010005, 32'h00003010, 32'h00003014, 1,0, 5'd0, 4'd1, 4'd0, 32'h00003010, 32'h00003014, 0, 5'd0};
        vecs[2]  = '{0,0,0,1,1, 32'hDEADBEEF, 32'h00003050, 5'd3, 32'h24010005, 32'h00003010, 32'h00003014, 1,0, 5'd0, 4'd2, 4'd0, 32'h00003010, 32'h00003014, 0, 5'd0};
        vecs[3]  = '{0,0,0,1,1, 32'hDEADBEEF, 32'h00003050, 5'd3, 32'h24010005, 32'h00003010, 32'h00003014, 1,0, 5'd0, 4'd3, 4'd0, 32'h00003010, 32'h00003014, 0, 5'd0};
        vecs[4]  = '{0,0,1,1,1, 32'hDEADBEEF, 32'h00003050, 5'd3, 32'h24010005, 32'h00003010, 32'h00003014, 1,0, 5'd0, 4'd0, 4'd0, 32'h00003010, 32'h00003014, 0, 5'd0};
        vecs[5]  = '{0,1,0,1,1, 32'hDEADBEEF, 32'h00003020, 5'd7, 32'h00000000, 32'h00003020, 32'h00003024, 0,1, 5'd0, 4'd0, 4'd1, 32'h00000000, 32'h00000004, 0, 5'd0};
        vecs[6]  = '{0,0,0,1,0, 32'hDEADBEEF, 32'h00003050, 5'd3, 32'h00000000, 32'h00003020, 32'h00003024, 0,1, 5'd0, 4'd0, 4'd1, 32'h00000000, 32'h00000004, 0, 5'd0};
        vecs[7]  = '{1,0,0,1,0, 32'h11111111, 32'h00003002, 5'd0, 32'h00000000, 32'h00003002, 32'h00003006, 1,0, 5'd4, 4'd0, 4'd1, 32'h00003002, 32'h00003006, 0, 5'd0};
        vecs[8]  = '{1,0,0,1,0, 32'h22222222, 32'h00003002, 5'd10,32'h22222222, 32'h00003002, 32'h00003006, 1,0, 5'd10,4'd0, 4'd1, 32'h00003002, 32'h00003006, 0, 5'd10};
        vecs[9]  = '{1,0,0,1,0, 32'h33333333, 32'hFFFFFFFC, 5'd0, 32'h33333333, 32'hFFFFFFFC, 32'h00000000, 1,0, 5'd0, 4'd0, 4'd1, 32'hFFFFFFFC, 32'h00000000, 0, 5'd0};
        vecs[10] = '{1,0,0,0,1, 32'h44444444, 32'h00003007, 5'd0, 32'h44444444, 32'h00003007, 32'h0000300B, 0,1, 5'd0, 4'd0, 4'd1, 32'h00003007, 32'h0000300B, 1, 5'd0};
        vecs[11] = '{1,1,1,1,0, 32'h55555555, 32'h00003100, 5'd0, 32'h00000000, 32'h00003100, 32'h00003104, 0,0, 5'd0, 4'd0, 4'd0, 32'h00000000, 32'h00000004, 0, 5'd0};
        vecs[12] = '{1,1,0,1,1, 32'h55555555, 32'h00003200, 5'd0, 32'h00000000, 32'h00003200, 32'h00003204, 0,1, 5'd0, 4'd0, 4'd1, 32'h00000000, 32'h00000004, 0, 5'd0};

        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset A instr", a_instr, 32'h0);
        chk("reset A pc", a_pc, 32'h00003000);
        chk("reset A pc4", a_pc4, 32'h00003004);
        chk("reset A valid", 32'(a_valid), 32'h0);
        chk("reset A cnts", {24'h0, a_sc, a_fc}, 32'h0);
        chk("reset B pc", b_pc, 32'h00003000);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].fl, vecs[i].clr, vecs[i].valid, vecs[i].bd,
                  vecs[i].instr, vecs[i].pc, vecs[i].exc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d A instr", i), a_instr, vecs[i].e_instr);
            chk($sformatf("v%0d A pc", i), a_pc, vecs[i].e_pc);
            chk($sformatf("v%0d A pc4", i), a_pc4, vecs[i].e_pc4);
            chk($sformatf("v%0d A valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d A bd", i), 32'(a_bd), 32'(vecs[i].e_bd));
            chk($sformatf("v%0d A exc", i), 32'(a_exc), 32'(vecs[i].e_exc));
            chk($sformatf("v%0d A stallcnt", i), 32'(a_sc), 32'(vecs[i].e_sc));
            chk($sformatf("v%0d A flushcnt", i), 32'(a_fc), 32'(vecs[i].e_fc));
            chk($sformatf("v%0d B pc", i), b_pc, vecs[i].b_pc);
            chk($sformatf("v%0d B pc4", i), b_pc4, vecs[i].b_pc4);
            chk($sformatf("v%0d B bd", i), 32'(b_bd), 32'(vecs[i].b_bd));
            chk($sformatf("v%0d B exc", i), 32'(b_exc), 32'(vecs[i].b_exc));
            @(negedge clk);
        end

        // Load a valid instruction, then stall 20 edges: 4-bit counter saturates
        drive(1, 0, 0, 1, 0, 32'h66666666, 32'h00003300, 5'd0);
        @(posedge clk); #1;
        chk("seq load A valid", 32'(a_valid), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h77777777, 32'h00003400, 5'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("seq stall A stallcnt sat", 32'(a_sc), 32'd15);
        chk("seq stall B stallcnt", 32'(b_sc), 32'd20);
        chk("seq stall A pc held", a_pc, 32'h00003300);
        chk("seq stall A instr held", a_instr, 32'h66666666);

        // 20 flushes on top of the existing count of 1
        @(negedge clk);
        drive(0, 1, 0, 1, 0, 32'h77777777, 32'h00003400, 5'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("seq flush A flushcnt sat", 32'(a_fc), 32'd15);
        chk("seq flush B flushcnt", 32'(b_fc), 32'd21);

        // Reset asserted between edges takes effect immediately
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst A pc", a_pc, 32'h00003000);
        chk("async rst A pc4", a_pc4, 32'h00003004);
        chk("async rst A valid", 32'(a_valid), 32'h0);
        chk("async rst A cnts", {24'h0, a_sc, a_fc}, 32'h0);
        chk("async rst B cnts", {b_sc, b_fc}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
